// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared constants and types for the drawbridge sensor path
package bridge_pkg;

    // Default debounce window and chatter threshold (samples / aborted attempts).
    localparam int unsigned DEBOUNCE_DEFAULT   = 4;
    localparam int unsigned GLITCH_MAX_DEFAULT = 8;

    // Sensor channel indices into the packed sensor vectors.
    localparam int unsigned NUM_SENSORS = 6;
    localparam int unsigned S1_IDX = 0;
    localparam int unsigned S2_IDX = 1;
    localparam int unsigned S3_IDX = 2;
    localparam int unsigned S4_IDX = 3;
    localparam int unsigned S5_IDX = 4;
    localparam int unsigned S6_IDX = 5;

    // Warm-up counter must hold 2 + 255.
    localparam int unsigned WARM_W = 9;

    // Bridge lifting-state encoding consumed by the downstream state logic.
    typedef enum logic [1:0] {
        BRIDGE_CLOSED   = 2'd0,
        BRIDGE_LIFTING  = 2'd1,
        BRIDGE_UPRIGHT  = 2'd2,
        BRIDGE_LOWERING = 2'd3
    } bridge_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - one sensor channel: synchroniser, debounce and chatter counter
module sensor_debounce
    import bridge_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = DEBOUNCE_DEFAULT,
    parameter int unsigned GLITCH_MAX = GLITCH_MAX_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic update_o,
    output logic fault_o
);

    localparam logic [7:0] LAST_CNT  = 8'(DEBOUNCE - 1);
    localparam logic [7:0] GLITCH_TH = 8'(GLITCH_MAX);

    logic       sync1_q;
    logic       y_q;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gcnt_q, gcnt_d;
    logic       update;

    // Two-flop synchroniser for the asynchronous raw level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            y_q     <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            y_q     <= sync1_q;
        end
    end

    // Debounce decision: count disagreeing samples, flip on the last one, abort on agreement.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        update  = 1'b0;
        if (y_q != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = y_q;
                cnt_d   = 8'd0;
                gcnt_d  = 8'd0;
                update  = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (cnt_q != 8'd0) begin
            cnt_d  = 8'd0;
            gcnt_d = sat_inc8(gcnt_q);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            cnt_q   <= 8'd0;
            gcnt_q  <= 8'd0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // The update strobe and fault bit come from registered state only; the top registers them.
    assign level_o  = level_q;
    assign update_o = update;
    assign fault_o  = (gcnt_q >= GLITCH_TH);

endmodule

// File: rtl/bridge_sensor_conditioner.sv
// rtl/bridge_sensor_conditioner.sv - six-channel bridge sensor debounce with Change/Valid/Fault
module bridge_sensor_conditioner
    import bridge_pkg::*;
#(
    parameter int unsigned DEBOUNCE   = DEBOUNCE_DEFAULT,
    parameter int unsigned GLITCH_MAX = GLITCH_MAX_DEFAULT
) (
    input  logic Clock,
    input  logic Reset,
    input  logic RawS1,
    input  logic RawS2,
    input  logic RawS3,
    input  logic RawS4,
    input  logic RawS5,
    input  logic RawS6,
    output logic S1,
    output logic S2,
    output logic S3,
    output logic S4,
    output logic S5,
    output logic S6,
    output logic Change,
    output logic Valid,
    output logic Fault
);

    localparam logic [WARM_W-1:0] WARM_END = WARM_W'(2 + DEBOUNCE);

    logic [NUM_SENSORS-1:0] raw;
    logic [NUM_SENSORS-1:0] level;
    logic [NUM_SENSORS-1:0] update;
    logic [NUM_SENSORS-1:0] chan_fault;

    logic              change_q;
    logic              valid_q;
    logic              fault_q;
    logic [WARM_W-1:0] warm_q, warm_d;

    assign raw[S1_IDX] = RawS1;
    assign raw[S2_IDX] = RawS2;
    assign raw[S3_IDX] = RawS3;
    assign raw[S4_IDX] = RawS4;
    assign raw[S5_IDX] = RawS5;
    assign raw[S6_IDX] = RawS6;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
        sensor_debounce #(
            .DEBOUNCE   (DEBOUNCE),
            .GLITCH_MAX (GLITCH_MAX)
        ) u_chan (
            .clk_i    (Clock),
            .rst_ni   (Reset),
            .raw_i    (raw[i]),
            .level_o  (level[i]),
            .update_o (update[i]),
            .fault_o  (chan_fault[i])
        );
    end

    // Warm-up counter stops once it reaches the end of the first settle window.
    always_comb begin
        warm_d = warm_q;
        if (warm_q != WARM_END) begin
            warm_d = warm_q + 1'b1;
        end
    end

    // Change follows the channel updates in the same cycle; Valid and Fault are sticky.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            warm_q   <= '0;
            change_q <= 1'b0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            warm_q   <= warm_d;
            change_q <= |update;
            valid_q  <= valid_q | (warm_d == WARM_END);
            fault_q  <= fault_q | (|chan_fault);
        end
    end

    assign S1     = level[S1_IDX];
    assign S2     = level[S2_IDX];
    assign S3     = level[S3_IDX];
    assign S4     = level[S4_IDX];
    assign S5     = level[S5_IDX];
    assign S6     = level[S6_IDX];
    assign Change = change_q;
    assign Valid  = valid_q;
    assign Fault  = fault_q;

endmodule

// File: tb/tb_bridge_sensor_conditioner.sv
// tb/tb_bridge_sensor_conditioner.sv - scoreboard bench for bridge_sensor_conditioner
module tb_bridge_sensor_conditioner;

    localparam int D = 4;
    localparam int G = 8;

    logic       Clock;
    logic       Reset;
    logic [5:0] raw;
    logic [5:0] raw1;
    logic       S1, S2, S3, S4, S5, S6, Change, Valid, Fault;
    logic [5:0] d1_s;
    logic       d1_change, d1_valid, d1_fault;

    int errors = 0;
    int checks = 0;

    bridge_sensor_conditioner dut (
        .Clock (Clock), .Reset (Reset),
        .RawS1 (raw[0]), .RawS2 (raw[1]), .RawS3 (raw[2]),
        .RawS4 (raw[3]), .RawS5 (raw[4]), .RawS6 (raw[5]),
        .S1 (S1), .S2 (S2), .S3 (S3), .S4 (S4), .S5 (S5), .S6 (S6),
        .Change (Change), .Valid (Valid), .Fault (Fault)
    );

    bridge_sensor_conditioner #(.DEBOUNCE(1), .GLITCH_MAX(8)) dut1 (
        .Clock (Clock), .Reset (Reset),
        .RawS1 (raw1[0]), .RawS2 (raw1[1]), .RawS3 (raw1[2]),
        .RawS4 (raw1[3]), .RawS5 (raw1[4]), .RawS6 (raw1[5]),
        .S1 (d1_s[0]), .S2 (d1_s[1]), .S3 (d1_s[2]),
        .S4 (d1_s[3]), .S5 (d1_s[4]), .S6 (d1_s[5]),
        .Change (d1_change), .Valid (d1_valid), .Fault (d1_fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: each channel sees the raw level two edges late, needs D
    // consecutive disagreeing samples to flip, and an interrupted run is one abort.
    bit   m_h1  [6];
    bit   m_h2  [6];
    bit   m_out [6];
    int   m_run [6];
    int   m_ab  [6];
    int   m_edges;
    bit   m_chg, m_valid, m_fault;
    logic [5:0] cap_raw = '0;
    logic       cap_rst = 1'b0;
    logic [8:0] exp_q [$];

    task automatic model_clear();
        for (int i = 0; i < 6; i++) begin
            m_h1[i] = 0; m_h2[i] = 0; m_out[i] = 0; m_run[i] = 0; m_ab[i] = 0;
        end
        m_edges = 0; m_chg = 0; m_valid = 0; m_fault = 0;
    endtask

    task automatic model_step(input logic [5:0] r);
        bit any_ab;
        bit y;
        any_ab = 0;
        for (int i = 0; i < 6; i++) if (m_ab[i] >= G) any_ab = 1;
        m_chg = 0;
        for (int i = 0; i < 6; i++) begin
            y = m_h2[i];
            m_h2[i] = m_h1[i];
            m_h1[i] = r[i];
            if (y != m_out[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == D) begin
                    m_out[i] = y; m_run[i] = 0; m_ab[i] = 0; m_chg = 1;
                end
            end else if (m_run[i] > 0) begin
                m_run[i] = 0;
                if (m_ab[i] < 255) m_ab[i] = m_ab[i] + 1;
            end
        end
        m_fault = m_fault | any_ab;
        if (m_edges < 1000) m_edges = m_edges + 1;
        m_valid = (m_edges >= 2 + D);
    endtask

    // Capture what the DUT sees at each active edge.
    initial forever begin
        @(posedge Clock);
        cap_raw = raw;
        cap_rst = Reset;
    end

    // Model advances once per cycle and queues the expected output vector.
    initial begin
        model_clear();
        forever begin
            @(negedge Clock);
            if (!Reset || !cap_rst) model_clear();
            else model_step(cap_raw);
            exp_q.push_back({m_out[5], m_out[4], m_out[3], m_out[2], m_out[1], m_out[0],
                             m_chg, m_valid, m_fault});
        end
    end

    // Monitor: pops one expectation per cycle and compares against the DUT.
    initial begin
        logic [8:0] e, a;
        int cyc;
        cyc = 0;
        forever begin
            @(negedge Clock);
            #1;
            cyc++;
            a = {S6, S5, S4, S3, S2, S1, Change, Valid, Fault};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty cycle %0d: got %b with no expectation", cyc, a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard cycle %0d: got %b expected %b ({S6..S1,Change,Valid,Fault})",
                             cyc, a, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        int chg_cnt;
        raw   = '0;
        raw1  = '0;
        Reset = 1'b0;
        repeat (3) tick();
        chk("reset_state", {S6, S5, S4, S3, S2, S1, Change, Valid, Fault}, 0);
        Reset = 1'b1;

        // Valid after exactly 2+D edges, no Change with all-low inputs.
        for (int n = 1; n <= 8; n++) begin
            tick();
            chk("valid_warmup", Valid, (n >= 2 + D) ? 1 : 0);
            chk("idle_no_change", Change, 0);
        end

        // Single step on S3.
        raw[2] = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            chk("s3_step", S3, (n >= 6) ? 1 : 0);
            chk("s3_change", Change, (n == 6) ? 1 : 0);
            chk("s3_others_low", {S6, S5, S4, S2, S1}, 0);
        end

        // Ten short pulses on S1: never propagate, Fault from the 8th abort.
        for (int p = 0; p < 10; p++) begin
            raw[0] = 1'b1;
            repeat (3) tick();
            raw[0] = 1'b0;
            repeat (6) tick();
            chk("s1_glitch_blocked", S1, 0);
            chk("fault_after_glitches", Fault, (p >= G - 1) ? 1 : 0);
        end

        // Simultaneous steps on S2 and S6 share one Change pulse.
        raw[1] = 1'b1;
        raw[5] = 1'b1;
        chg_cnt = 0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            if (Change) chg_cnt++;
            if (n == 5) chk("s2s6_before", {S2, S6}, 0);
            if (n == 6) chk("s2s6_together", {S2, S6}, 3);
        end
        chk("s2s6_one_change", chg_cnt, 1);

        // Reset in the middle of an S5 debounce.
        raw[4] = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        #1;
        chk("async_reset_clear", {S6, S5, S4, S3, S2, S1, Change, Valid, Fault}, 0);
        tick();
        Reset = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            chk("s5_after_reset", S5, (n >= 6) ? 1 : 0);
            chk("valid_rerise", Valid, (n >= 6) ? 1 : 0);
            chk("fault_cleared", Fault, 0);
        end

        // Randomised traffic with occasional resets; the scoreboard checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 2 + 3 * i) == 0) raw[i] = ~raw[i];
            end
            if ($urandom_range(0, 599) == 0) begin
                Reset = 1'b0;
                repeat (1 + $urandom_range(0, 2)) tick();
                Reset = 1'b1;
            end
            tick();
        end

        // DEBOUNCE=1 instance: step after 2 edges, 1-cycle pulse stays 1 cycle.
        raw = '0;
        repeat (10) tick();
        raw1[3] = 1'b1;
        tick();
        chk("d1_step_e0", d1_s[3], 0);
        tick();
        chk("d1_step_e1", d1_s[3], 0);
        tick();
        chk("d1_step_e2", d1_s[3], 1);
        chk("d1_step_change", d1_change, 1);
        raw1[3] = 1'b0;
        repeat (4) tick();
        chk("d1_back_low", d1_s[3], 0);
        raw1[3] = 1'b1;
        tick();
        raw1[3] = 1'b0;
        chk("d1_pulse_e0", d1_s[3], 0);
        tick();
        chk("d1_pulse_e1", d1_s[3], 0);
        tick();
        chk("d1_pulse_e2", d1_s[3], 1);
        tick();
        chk("d1_pulse_e3", d1_s[3], 0);
        chk("d1_valid", d1_valid, 1);
        chk("d1_no_fault", d1_fault, 0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
